// File: rtl/pipe_ctrl_ex_mem.sv
// Purpose: nPC+4 adder plus ID/EX and EX/MEM control-word pipeline registers with field taps.
// Latency: adder 0 cycles; control word reaches EX after 1 edge, MEM after 2 edges.
// Backpressure: none; one word accepted per clock, NOPs are injected upstream as all-zero words.
module pipe_ctrl_ex_mem (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] adder_in,
   output logic [31:0] adder_out,
   input  logic [16:0] id_control_signals,
   output logic [16:0] ex_control_signals,
   output logic [2:0]  ex_source_operand,
   output logic [2:0]  ex_alu_op,
   output logic        ex_load_instr,
   output logic        ex_rf_enable,
   output logic        ex_branch_instr,
   output logic [16:0] mem_control_signals,
   output logic        mem_load_instr,
   output logic        mem_rf_enable,
   output logic [1:0]  mem_size,
   output logic        mem_rw,
   output logic        mem_se,
   output logic        mem_enable
);

   logic [16:0] ex_ctrl_d;
   logic [16:0] ex_ctrl_q;
   logic [16:0] mem_ctrl_d;
   logic [16:0] mem_ctrl_q;

   // PC increment; wraps modulo 2^32 with the carry dropped, independent of reset.
   always_comb begin
      adder_out = adder_in + 32'd4;
   end

   // Next-state: each stage takes the previous stage's word untouched.
   always_comb begin
      ex_ctrl_d  = id_control_signals;
      mem_ctrl_d = ex_ctrl_q;
   end

   // Stage registers; synchronous reset loads the NOP word and wins over the data load.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ctrl_q  <= 17'd0;
         mem_ctrl_q <= 17'd0;
      end else begin
         ex_ctrl_q  <= ex_ctrl_d;
         mem_ctrl_q <= mem_ctrl_d;
      end
   end

   // Field taps are plain slices of the stage registers.
   always_comb begin
      ex_control_signals  = ex_ctrl_q;
      ex_source_operand   = ex_ctrl_q[16:14];
      ex_alu_op           = ex_ctrl_q[13:11];
      ex_load_instr       = ex_ctrl_q[10];
      ex_rf_enable        = ex_ctrl_q[9];
      ex_branch_instr     = ex_ctrl_q[8];
      mem_control_signals = mem_ctrl_q;
      mem_load_instr      = mem_ctrl_q[10];
      mem_rf_enable       = mem_ctrl_q[9];
      mem_size            = mem_ctrl_q[6:5];
      mem_rw              = mem_ctrl_q[4];
      mem_se              = mem_ctrl_q[3];
      mem_enable          = mem_ctrl_q[0];
   end

endmodule

// File: tb/tb_pipe_ctrl_ex_mem.sv
// Purpose: directed self-checking bench for the EX/MEM control pipeline and nPC adder.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_pipe_ctrl_ex_mem;

   logic        clk;
   logic        reset;
   logic [31:0] adder_in;
   logic [31:0] adder_out;
   logic [16:0] id_control_signals;
   logic [16:0] ex_control_signals;
   logic [2:0]  ex_source_operand;
   logic [2:0]  ex_alu_op;
   logic        ex_load_instr;
   logic        ex_rf_enable;
   logic        ex_branch_instr;
   logic [16:0] mem_control_signals;
   logic        mem_load_instr;
   logic        mem_rf_enable;
   logic [1:0]  mem_size;
   logic        mem_rw;
   logic        mem_se;
   logic        mem_enable;

   int n_checks;
   int n_errors;

   pipe_ctrl_ex_mem dut (
      .clk                 (clk),
      .reset               (reset),
      .adder_in            (adder_in),
      .adder_out           (adder_out),
      .id_control_signals  (id_control_signals),
      .ex_control_signals  (ex_control_signals),
      .ex_source_operand   (ex_source_operand),
      .ex_alu_op           (ex_alu_op),
      .ex_load_instr       (ex_load_instr),
      .ex_rf_enable        (ex_rf_enable),
      .ex_branch_instr     (ex_branch_instr),
      .mem_control_signals (mem_control_signals),
      .mem_load_instr      (mem_load_instr),
      .mem_rf_enable       (mem_rf_enable),
      .mem_size            (mem_size),
      .mem_rw              (mem_rw),
      .mem_se              (mem_se),
      .mem_enable          (mem_enable)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle past it.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ex_ctrl"},  {15'd0, ex_control_signals},  32'd0);
      chk({tag, " mem_ctrl"}, {15'd0, mem_control_signals}, 32'd0);
      chk({tag, " ex_fields"},
          {21'd0, ex_source_operand, ex_alu_op, ex_load_instr, ex_rf_enable, ex_branch_instr}, 32'd0);
      chk({tag, " mem_fields"},
          {25'd0, mem_load_instr, mem_rf_enable, mem_size, mem_rw, mem_se, mem_enable}, 32'd0);
   endtask

   logic [31:0] add_in_v  [4];
   logic [31:0] add_exp_v [4];

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      adder_in = 32'd0;
      id_control_signals = 17'h1FFFF;

      // Reset held for two edges with an all-ones word at the input.
      step;
      chk_all_zero("reset1");
      step;
      chk_all_zero("reset2");

      // Release: word reaches EX after one edge, MEM after two.
      reset = 1'b0;
      step;
      chk("rel ex",  {15'd0, ex_control_signals},  32'h1FFFF);
      chk("rel mem", {15'd0, mem_control_signals}, 32'h00000);
      step;
      chk("rel mem2", {15'd0, mem_control_signals}, 32'h1FFFF);

      // Field decode of 1ABCD.
      id_control_signals = 17'h1ABCD;
      step;
      id_control_signals = 17'h00000;
      chk("ex_src",    {29'd0, ex_source_operand}, 32'b110);
      chk("ex_alu",    {29'd0, ex_alu_op},         32'b101);
      chk("ex_load",   {31'd0, ex_load_instr},     32'd0);
      chk("ex_rf",     {31'd0, ex_rf_enable},      32'd1);
      chk("ex_branch", {31'd0, ex_branch_instr},   32'd1);
      step;
      chk("mem_size",  {30'd0, mem_size},       32'b10);
      chk("mem_rw",    {31'd0, mem_rw},         32'd0);
      chk("mem_se",    {31'd0, mem_se},         32'd1);
      chk("mem_en",    {31'd0, mem_enable},     32'd1);
      chk("mem_load",  {31'd0, mem_load_instr}, 32'd0);
      chk("mem_rf",    {31'd0, mem_rf_enable},  32'd1);
      chk("ex_nop",    {15'd0, ex_control_signals}, 32'd0);

      // Back-to-back words appear on MEM on consecutive cycles.
      id_control_signals = 17'h00001;
      step;
      id_control_signals = 17'h00200;
      step;
      chk("b2b mem0", {15'd0, mem_control_signals}, 32'h00001);
      id_control_signals = 17'h10000;
      step;
      chk("b2b mem1", {15'd0, mem_control_signals}, 32'h00200);
      chk("b2b ex2",  {15'd0, ex_control_signals},  32'h10000);
      id_control_signals = 17'h00000;
      step;
      chk("b2b mem2", {15'd0, mem_control_signals}, 32'h10000);

      // Mid-stream reset with 1ABCD in EX and 00200 in MEM.
      id_control_signals = 17'h00200;
      step;
      id_control_signals = 17'h1ABCD;
      step;
      chk("pre ex",  {15'd0, ex_control_signals},  32'h1ABCD);
      chk("pre mem", {15'd0, mem_control_signals}, 32'h00200);
      reset = 1'b1;
      id_control_signals = 17'h00001;
      step;
      chk_all_zero("midrst");
      reset = 1'b0;
      step;
      chk("post ex",  {15'd0, ex_control_signals},  32'h00001);
      chk("post mem", {15'd0, mem_control_signals}, 32'h00000);
      id_control_signals = 17'h00000;
      step;
      chk("post mem2", {15'd0, mem_control_signals}, 32'h00001);

      // Adder, including wrap past 2^32.
      add_in_v[0] = 32'h0000_0000; add_exp_v[0] = 32'h0000_0004;
      add_in_v[1] = 32'h0000_0100; add_exp_v[1] = 32'h0000_0104;
      add_in_v[2] = 32'hFFFF_FFFC; add_exp_v[2] = 32'h0000_0000;
      add_in_v[3] = 32'hFFFF_FFFE; add_exp_v[3] = 32'h0000_0002;
      for (int i = 0; i < 4; i++) begin
         adder_in = add_in_v[i];
         #1;
         chk($sformatf("adder%0d", i), adder_out, add_exp_v[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
